multiplicador_parametrizado: RTL and testbench

Sequential shift-and-add multiplier, the parametrised successor to the team's fixed 4-bit multiplier. It takes two N-bit operands and returns a 2N-bit product. Each operation selects signed (two's complement) or unsigned mode. It keeps the existing st/done/idle handshake and adds a synchronous reset, a sign-correction stage and back-to-back operation. It sits as a multi-cycle arithmetic unit behind a controller that pulses st and waits for done.

---
 rtl/multiplicador_parametrizado_if.sv | 23 ++
 rtl/multiplicador_parametrizado.sv | 102 ++++++++++
 tb/tb_multiplicador_parametrizado.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/multiplicador_parametrizado_if.sv
// Start/done handshake and operand/result bus of the shift-and-add multiplier.
// The master is the controller that issues operations; the slave is the multiplier.
interface multiplicador_parametrizado_if #(
    parameter int N = 4
);
    logic             st;
    logic             sinal;
    logic [N-1:0]     multiplicando;
    logic [N-1:0]     multiplicador;
    logic [2*N-1:0]   produto;
    logic             done;
    logic             idle;

    modport master (
        output st, sinal, multiplicando, multiplicador,
        input  produto, done, idle
    );

    modport slave (
        input  st, sinal, multiplicando, multiplicador,
        output produto, done, idle
    );
endinterface

// File: rtl/multiplicador_parametrizado.sv
// Sequential N x N shift-and-add multiplier, signed or unsigned per operation,
// with sign correction after the magnitude product and back-to-back restart from DONE.
module multiplicador_parametrizado #(
    parameter int N = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    multiplicador_parametrizado_if.slave  bus
);
    localparam int KW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        AJUSTE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_reg;
    logic [KW-1:0]     k_reg;
    logic [2*N:0]      acc_reg;
    logic [N-1:0]      mcand_reg;
    logic              neg_reg;
    logic [2*N-1:0]    produto_reg;
    logic              done_reg;
    logic              idle_reg;

    logic [N-1:0]      mag_a;
    logic [N-1:0]      mag_b;
    logic              neg_next;
    logic [N:0]        sum;
    logic [2*N:0]      acc_next;
    logic [2*N-1:0]    result;

    // Magnitudes are N-bit unsigned; -2^(N-1) negates onto itself, which is exactly 2^(N-1).
    always_comb begin
        mag_a    = bus.multiplicando;
        mag_b    = bus.multiplicador;
        neg_next = 1'b0;
        if (bus.sinal) begin
            if (bus.multiplicando[N-1]) mag_a = -bus.multiplicando;
            if (bus.multiplicador[N-1]) mag_b = -bus.multiplicador;
            neg_next = bus.multiplicando[N-1] ^ bus.multiplicador[N-1];
        end
    end

    // The upper N+1 bits take the partial sum; the carry lands in bit 2N before the shift.
    always_comb begin
        sum      = acc_reg[2*N:N] + (acc_reg[0] ? {1'b0, mcand_reg} : {(N+1){1'b0}});
        acc_next = {sum, acc_reg[N-1:0]} >> 1;
        result   = neg_reg ? -acc_reg[2*N-1:0] : acc_reg[2*N-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            k_reg       <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            neg_reg     <= 1'b0;
            produto_reg <= '0;
            done_reg    <= 1'b0;
            idle_reg    <= 1'b1;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (bus.st) begin
                        acc_reg   <= {{(N+1){1'b0}}, mag_b};
                        mcand_reg <= mag_a;
                        neg_reg   <= neg_next;
                        k_reg     <= '0;
                        idle_reg  <= 1'b0;
                        state_reg <= CALC;
                    end else begin
                        idle_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    acc_reg <= acc_next;
                    if (k_reg == KW'(N - 1)) begin
                        k_reg     <= '0;
                        state_reg <= AJUSTE;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                AJUSTE: begin
                    produto_reg <= result;
                    done_reg    <= 1'b1;
                    state_reg   <= DONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.produto = produto_reg;
    assign bus.done    = done_reg;
    assign bus.idle    = idle_reg;
endmodule

// File: tb/tb_multiplicador_parametrizado.sv
// Scoreboard bench: drivers push hand-computed products, per-DUT monitors pop on done.
module tb_multiplicador_parametrizado;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiplicador_parametrizado_if #(.N(4)) if4 ();
    multiplicador_parametrizado_if #(.N(8)) if8 ();

    multiplicador_parametrizado #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    multiplicador_parametrizado #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp4[$];
    string       nm4[$];
    logic [15:0] exp8[$];
    string       nm8[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, required);
        end
    endtask

    // Monitors: compare every done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && if4.done) begin
            logic [7:0] e;
            string      n;
            check("n4_done_idle_exclusive", {31'd0, if4.idle}, 32'd0);
            checks++;
            if (exp4.size() == 0) begin
                errors++;
                $display("FAIL n4_unexpected_done: got produto %0h expected no result", if4.produto);
            end else begin
                e = exp4.pop_front();
                n = nm4.pop_front();
                if (if4.produto !== e) begin
                    errors++;
                    $display("FAIL n4_%s: got %0h expected %0h", n, if4.produto, e);
                end else begin
                    $display("n4 %s produto=%0h ok", n, if4.produto);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if8.done) begin
            logic [15:0] e;
            string       n;
            check("n8_done_idle_exclusive", {31'd0, if8.idle}, 32'd0);
            checks++;
            if (exp8.size() == 0) begin
                errors++;
                $display("FAIL n8_unexpected_done: got produto %0h expected no result", if8.produto);
            end else begin
                e = exp8.pop_front();
                n = nm8.pop_front();
                if (if8.produto !== e) begin
                    errors++;
                    $display("FAIL n8_%s: got %0h expected %0h", n, if8.produto, e);
                end else begin
                    $display("n8 %s produto=%0h ok", n, if8.produto);
                end
            end
        end
    end

    // One isolated operation; st and operands are scrambled during CALC to prove they are ignored.
    task automatic run4(input logic s, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] e, input string name);
        int lat;
        @(negedge clk);
        if4.st = 1'b1; if4.sinal = s; if4.multiplicando = a; if4.multiplicador = b;
        exp4.push_back(e); nm4.push_back(name);
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (!if4.done && lat < 40) begin
            if4.st = (lat < 4) ? 1'($urandom) : 1'b0;
            if4.sinal = 1'($urandom);
            if4.multiplicando = 4'($urandom);
            if4.multiplicador = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        check({"n4_latency_", name}, lat, 5);
        @(negedge clk);
        check({"n4_done_width_", name}, {31'd0, if4.done}, 32'd0);
        check({"n4_idle_after_", name}, {31'd0, if4.idle}, 32'd1);
    endtask

    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] e, input string name);
        int lat;
        @(negedge clk);
        if8.st = 1'b1; if8.sinal = s; if8.multiplicando = a; if8.multiplicador = b;
        exp8.push_back(e); nm8.push_back(name);
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (!if8.done && lat < 40) begin
            if8.st = (lat < 8) ? 1'($urandom) : 1'b0;
            if8.sinal = 1'($urandom);
            if8.multiplicando = 8'($urandom);
            if8.multiplicador = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        check({"n8_latency_", name}, lat, 9);
        @(negedge clk);
        check({"n8_done_width_", name}, {31'd0, if8.done}, 32'd0);
        check({"n8_idle_after_", name}, {31'd0, if8.idle}, 32'd1);
    endtask

    initial begin
        int lat;
        int wait_cycles;
        if4.st = 1'b0; if4.sinal = 1'b0; if4.multiplicando = '0; if4.multiplicador = '0;
        if8.st = 1'b0; if8.sinal = 1'b0; if8.multiplicando = '0; if8.multiplicador = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("n4_reset_idle", {31'd0, if4.idle}, 32'd1);
        check("n4_reset_done", {31'd0, if4.done}, 32'd0);
        check("n4_reset_produto", {24'd0, if4.produto}, 32'd0);
        check("n8_reset_idle", {31'd0, if8.idle}, 32'd1);
        check("n8_reset_done", {31'd0, if8.done}, 32'd0);
        check("n8_reset_produto", {16'd0, if8.produto}, 32'd0);
        rst = 1'b0;

        run4(1'b0, 4'd13, 4'd11, 8'h8F, "u13x11");
        run4(1'b1, 4'hD,  4'h5,  8'hF1, "s_m3x5");
        run4(1'b1, 4'h8,  4'h8,  8'h40, "s_m8xm8");
        run4(1'b1, 4'h7,  4'h8,  8'hC8, "s_7xm8");
        run4(1'b1, 4'h0,  4'hB,  8'h00, "s_0xm5");

        // Back-to-back: st stays high through DONE with new operands.
        @(negedge clk);
        if4.st = 1'b1; if4.sinal = 1'b0; if4.multiplicando = 4'd7; if4.multiplicador = 4'd15;
        exp4.push_back(8'h69); nm4.push_back("b2b_7x15");
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        if4.multiplicando = 4'd15; if4.multiplicador = 4'd15;
        exp4.push_back(8'hE1); nm4.push_back("b2b_15x15");
        while (!if4.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first_latency", lat, 5);
        @(negedge clk);
        lat++;
        check("b2b_no_idle_between", {31'd0, if4.idle}, 32'd0);
        if4.st = 1'b0; if4.multiplicando = 4'd3; if4.multiplicador = 4'd2;
        while (!if4.done && lat < 40) begin
            if (lat == 10) check("b2b_produto_hold", {24'd0, if4.produto}, 32'h69);
            @(negedge clk);
            lat++;
        end
        check("b2b_second_latency", lat, 11);

        // Reset while k=2 in CALC: operation is dropped without a done.
        @(negedge clk);
        @(negedge clk);
        if4.st = 1'b1; if4.sinal = 1'b0; if4.multiplicando = 4'd9; if4.multiplicador = 4'd9;
        @(posedge clk);
        @(negedge clk);
        if4.st = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_calc_idle", {31'd0, if4.idle}, 32'd1);
        check("rst_mid_calc_produto", {24'd0, if4.produto}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_no_late_done_idle", {31'd0, if4.idle}, 32'd1);
        run4(1'b0, 4'd5, 4'd6, 8'h1E, "u5x6_after_rst");

        run8(1'b0, 8'd255, 8'd255, 16'hFE01, "u255x255");
        run8(1'b1, 8'h80,  8'h80,  16'h4000, "s_m128xm128");
        run8(1'b1, 8'h05,  8'hFD,  16'hFFF1, "s_5xm3");

        wait_cycles = 0;
        while ((exp4.size() != 0 || exp8.size() != 0) && wait_cycles < 50) begin
            @(negedge clk);
            wait_cycles++;
        end
        check("n4_scoreboard_drained", exp4.size(), 0);
        check("n8_scoreboard_drained", exp8.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
